// File: rtl/riscv151_arb_pkg.sv
// riscv151_arb_pkg: shared FSM state codes, owner-tag encoding and burst limits for mem_port_arbiter.
package riscv151_arb_pkg;
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_OWN_IF = 2'd1;
    localparam logic [1:0] ST_OWN_D  = 2'd2;
    localparam logic [1:0] TAG_NONE  = 2'd0;
    localparam logic [1:0] TAG_IF    = 2'd1;
    localparam logic [1:0] TAG_D     = 2'd2;
    localparam int BURST_MIN = 1;
    localparam int BURST_MAX = 15;
    localparam int CNT_W     = 4;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch port, data port and memory-side signals of the arbiter.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req;
    logic [3:0]        d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic              mem_en;
    logic [3:0]        mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_dout,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_din
    );
    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_dout,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_din
    );
endinterface

// File: rtl/arb_burst_counter.sv
// arb_burst_counter: consecutive-grant counter for the current owner and its MAX_BURST limit compare.
module arb_burst_counter
    import riscv151_arb_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic gnt,
    input  logic same,
    output logic limit_hit
);
    localparam logic [CNT_W-1:0] MAX = CNT_W'(MAX_BURST);
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clk or negedge rst)
        if (!rst) cnt <= '0;
        else cnt <= !gnt ? '0 : !same ? CNT_W'(1) : (cnt == MAX) ? cnt : cnt + CNT_W'(1);
    assign limit_hit = cnt >= MAX;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: arbitrates fetch and data ports onto one single-port sync memory with burst limiting.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin IDLE tie-break; otherwise the data port wins ties.
module mem_port_arbiter
    import riscv151_arb_pkg::*;
#(
    parameter int ADDR_W    = 14,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input logic clk,
    input logic rst,
    mem_port_arbiter_if.slave bus
);
    logic [1:0]        state, tag;
    logic              pick_d, idle_pick_d, gnt_if, gnt_d, same_owner, limit_hit;
    logic [ADDR_W-1:0] addr_sel;
    logic [DATA_W-1:0] if_rdata_q, d_rdata_q;

    if (MAX_BURST < BURST_MIN || MAX_BURST > BURST_MAX) begin : g_bad_burst
        $error("MAX_BURST out of legal range");
    end

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_d;
    always_ff @(posedge clk or negedge rst)
        if (!rst) last_d <= 1'b0;
        else if (gnt_if | gnt_d) last_d <= gnt_d;
    assign idle_pick_d = !last_d;
`else
    assign idle_pick_d = 1'b1;
`endif

    // pick_d only matters when both ports request; a lone requester always wins
    assign pick_d = (state == ST_OWN_D) ? !limit_hit : (state == ST_OWN_IF) ? limit_hit : idle_pick_d;
    assign gnt_d = rst & bus.d_req & (!bus.if_req | pick_d);
    assign gnt_if = rst & bus.if_req & (!bus.d_req | !pick_d);
    assign same_owner = (gnt_d & (state == ST_OWN_D)) | (gnt_if & (state == ST_OWN_IF));

    arb_burst_counter #(.MAX_BURST(MAX_BURST)) u_burst (
        .clk      (clk),
        .rst      (rst),
        .gnt      (gnt_if | gnt_d),
        .same     (same_owner),
        .limit_hit(limit_hit)
    );

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state      <= ST_IDLE;
            tag        <= TAG_NONE;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state <= gnt_d ? ST_OWN_D : gnt_if ? ST_OWN_IF : ST_IDLE;
            tag   <= gnt_if ? TAG_IF : (gnt_d && bus.d_we == 4'b0) ? TAG_D : TAG_NONE;
            if (tag == TAG_IF) if_rdata_q <= bus.mem_dout;
            if (tag == TAG_D) d_rdata_q <= bus.mem_dout;
        end

    assign addr_sel      = gnt_d ? bus.d_addr : gnt_if ? bus.if_addr : '0;
    assign bus.if_gnt    = gnt_if;
    assign bus.d_gnt     = gnt_d;
    assign bus.mem_en    = gnt_if | gnt_d;
    assign bus.mem_we    = gnt_d ? bus.d_we : 4'b0;
    assign bus.mem_addr  = addr_sel;
    assign bus.mem_din   = gnt_d ? bus.d_wdata : '0;
    assign bus.if_rvalid = tag == TAG_IF;
    assign bus.d_rvalid  = tag == TAG_D;
    assign bus.if_rdata  = (tag == TAG_IF) ? bus.mem_dout : if_rdata_q;
    assign bus.d_rdata   = (tag == TAG_D) ? bus.mem_dout : d_rdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vector table plus burst, tie-break and reset sequences for mem_port_arbiter.
module tb_mem_port_arbiter;
    typedef struct {
        logic        ir;
        logic [13:0] ia;
        logic        dr;
        logic [3:0]  we;
        logic [13:0] da;
        logic [31:0] wd;
        logic [31:0] dout;
        logic        e_ig;
        logic        e_dg;
        logic        e_en;
        logic [3:0]  e_we;
        logic [13:0] e_addr;
        logic [31:0] e_din;
        logic        e_iv;
        logic [31:0] e_ir;
        logic        e_dv;
        logic [31:0] e_dr;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int errors = 0;
    int checks = 0;
    vec_t vecs[10];

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(14), .DATA_W(32)) bus ();

    mem_port_arbiter #(.ADDR_W(14), .DATA_W(32), .MAX_BURST(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ir, input logic [13:0] ia, input logic dr, input logic [3:0] we,
                         input logic [13:0] da, input logic [31:0] wd, input logic [31:0] dout);
        bus.if_req   = ir;
        bus.if_addr  = ia;
        bus.d_req    = dr;
        bus.d_we     = we;
        bus.d_addr   = da;
        bus.d_wdata  = wd;
        bus.mem_dout = dout;
    endtask

    task automatic cycle(input logic ir, input logic [13:0] ia, input logic dr, input logic [3:0] we,
                         input logic [13:0] da, input logic [31:0] wd, input logic [31:0] dout);
        @(negedge clk);
        drive(ir, ia, dr, we, da, wd, dout);
        #2;
    endtask

    initial begin
        logic exp_d, prev_d, tie_d;
        vecs[0] = '{1'b1, 14'h10, 1'b0, 4'h0, 14'h0, 32'h0, 32'h0,
                    1'b1, 1'b0, 1'b1, 4'h0, 14'h10, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0};
        vecs[1] = '{1'b0, 14'h0, 1'b0, 4'h0, 14'h0, 32'h0, 32'hDEADBEEF,
                    1'b0, 1'b0, 1'b0, 4'h0, 14'h0, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0};
        vecs[2] = '{1'b0, 14'h0, 1'b1, 4'hF, 14'h20, 32'h12345678, 32'h55,
                    1'b0, 1'b1, 1'b1, 4'hF, 14'h20, 32'h12345678, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0};
        vecs[3] = '{1'b0, 14'h0, 1'b0, 4'h0, 14'h0, 32'h0, 32'h66,
                    1'b0, 1'b0, 1'b0, 4'h0, 14'h0, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0};
        vecs[4] = '{1'b1, 14'h11, 1'b0, 4'hA, 14'h0, 32'h77, 32'h0,
                    1'b1, 1'b0, 1'b1, 4'h0, 14'h11, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0};
        vecs[5] = '{1'b0, 14'h0, 1'b1, 4'h0, 14'h21, 32'h0, 32'hA1,
                    1'b0, 1'b1, 1'b1, 4'h0, 14'h21, 32'h0, 1'b1, 32'hA1, 1'b0, 32'h0};
        vecs[6] = '{1'b1, 14'h12, 1'b0, 4'h0, 14'h0, 32'h0, 32'hB2,
                    1'b1, 1'b0, 1'b1, 4'h0, 14'h12, 32'h0, 1'b0, 32'hA1, 1'b1, 32'hB2};
        vecs[7] = '{1'b0, 14'h0, 1'b1, 4'h0, 14'h22, 32'h0, 32'hC3,
                    1'b0, 1'b1, 1'b1, 4'h0, 14'h22, 32'h0, 1'b1, 32'hC3, 1'b0, 32'hB2};
        vecs[8] = '{1'b0, 14'h0, 1'b0, 4'h0, 14'h0, 32'h0, 32'hD4,
                    1'b0, 1'b0, 1'b0, 4'h0, 14'h0, 32'h0, 1'b0, 32'hC3, 1'b1, 32'hD4};
        vecs[9] = '{1'b0, 14'h0, 1'b0, 4'h0, 14'h0, 32'h0, 32'hE5,
                    1'b0, 1'b0, 1'b0, 4'h0, 14'h0, 32'h0, 1'b0, 32'hC3, 1'b0, 32'hD4};

        // reset state with both requests pending
        drive(1'b1, 14'h5, 1'b1, 4'hF, 14'h6, 32'h99, 32'h1234);
        #2;
        chk("rst if_gnt", 32'(bus.if_gnt), 32'h0);
        chk("rst d_gnt", 32'(bus.d_gnt), 32'h0);
        chk("rst mem_en", 32'(bus.mem_en), 32'h0);
        chk("rst mem_we", 32'(bus.mem_we), 32'h0);
        chk("rst if_rdata", bus.if_rdata, 32'h0);
        chk("rst d_rdata", bus.d_rdata, 32'h0);
        chk("rst rvalid", 32'({bus.if_rvalid, bus.d_rvalid}), 32'h0);
        @(negedge clk);
        drive(1'b0, 14'h0, 1'b0, 4'h0, 14'h0, 32'h0, 32'h0);
        rst = 1'b1;

        for (int i = 0; i < 10; i++) begin
            cycle(vecs[i].ir, vecs[i].ia, vecs[i].dr, vecs[i].we, vecs[i].da, vecs[i].wd, vecs[i].dout);
            chk($sformatf("v%0d if_gnt", i), 32'(bus.if_gnt), 32'(vecs[i].e_ig));
            chk($sformatf("v%0d d_gnt", i), 32'(bus.d_gnt), 32'(vecs[i].e_dg));
            chk($sformatf("v%0d mem_en", i), 32'(bus.mem_en), 32'(vecs[i].e_en));
            chk($sformatf("v%0d mem_we", i), 32'(bus.mem_we), 32'(vecs[i].e_we));
            chk($sformatf("v%0d mem_addr", i), 32'(bus.mem_addr), 32'(vecs[i].e_addr));
            chk($sformatf("v%0d mem_din", i), bus.mem_din, vecs[i].e_din);
            chk($sformatf("v%0d if_rvalid", i), 32'(bus.if_rvalid), 32'(vecs[i].e_iv));
            chk($sformatf("v%0d if_rdata", i), bus.if_rdata, vecs[i].e_ir);
            chk($sformatf("v%0d d_rvalid", i), 32'(bus.d_rvalid), 32'(vecs[i].e_dv));
            chk($sformatf("v%0d d_rdata", i), bus.d_rdata, vecs[i].e_dr);
        end

        // both requesting for 12 cycles from IDLE: 4 data, 4 fetch, 4 data
        prev_d = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cycle(1'b1, 14'h30, 1'b1, 4'h0, 14'h40, 32'h0, 32'h100 + 32'(i));
            exp_d = ((i / 4) % 2) == 0;
            chk($sformatf("burst%0d d_gnt", i), 32'(bus.d_gnt), 32'(exp_d));
            chk($sformatf("burst%0d if_gnt", i), 32'(bus.if_gnt), 32'(!exp_d));
            chk($sformatf("burst%0d mem_addr", i), 32'(bus.mem_addr), exp_d ? 32'h40 : 32'h30);
            if (i > 0) begin
                chk($sformatf("burst%0d d_rvalid", i), 32'(bus.d_rvalid), 32'(prev_d));
                chk($sformatf("burst%0d if_rvalid", i), 32'(bus.if_rvalid), 32'(!prev_d));
                chk($sformatf("burst%0d rdata", i), prev_d ? bus.d_rdata : bus.if_rdata, 32'h100 + 32'(i));
            end
            prev_d = exp_d;
        end
        // lone data request past the burst limit is still granted
        cycle(1'b0, 14'h0, 1'b1, 4'h0, 14'h41, 32'h0, 32'h200);
        chk("lone d_gnt at limit", 32'(bus.d_gnt), 32'h1);
        chk("lone d_rdata", bus.d_rdata, 32'h200);
        // saturated data burst hands over to fetch
        cycle(1'b1, 14'h31, 1'b1, 4'h0, 14'h42, 32'h0, 32'h300);
        chk("handover if_gnt", 32'(bus.if_gnt), 32'h1);
        chk("handover d_gnt", 32'(bus.d_gnt), 32'h0);
        chk("handover d_rdata", bus.d_rdata, 32'h300);
        cycle(1'b0, 14'h0, 1'b0, 4'h0, 14'h0, 32'h0, 32'h400);
        chk("handover if_rvalid", 32'(bus.if_rvalid), 32'h1);
        chk("handover if_rdata", bus.if_rdata, 32'h400);
        chk("handover d_rvalid", 32'(bus.d_rvalid), 32'h0);

        // IDLE tie after data was the last winner
`ifdef MEM_ARB_ROUND_ROBIN_EN
        tie_d = 1'b0;
`else
        tie_d = 1'b1;
`endif
        cycle(1'b0, 14'h0, 1'b1, 4'h0, 14'h43, 32'h0, 32'h0);
        chk("tie prep d_gnt", 32'(bus.d_gnt), 32'h1);
        cycle(1'b0, 14'h0, 1'b0, 4'h0, 14'h0, 32'h0, 32'h0);
        cycle(1'b1, 14'h32, 1'b1, 4'h0, 14'h44, 32'h0, 32'h0);
        chk("idle tie d_gnt", 32'(bus.d_gnt), 32'(tie_d));
        chk("idle tie if_gnt", 32'(bus.if_gnt), 32'(!tie_d));

        // reset asserted the cycle after a fetch read grant
        cycle(1'b0, 14'h0, 1'b0, 4'h0, 14'h0, 32'h0, 32'h0);
        cycle(1'b1, 14'h50, 1'b0, 4'h0, 14'h0, 32'h0, 32'h0);
        chk("pre-rst if_gnt", 32'(bus.if_gnt), 32'h1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b1, 14'h50, 1'b1, 4'hF, 14'h51, 32'h77, 32'hBAD0BAD0);
        #1;
        chk("squash if_rvalid", 32'(bus.if_rvalid), 32'h0);
        chk("squash d_rvalid", 32'(bus.d_rvalid), 32'h0);
        chk("squash gnt", 32'({bus.if_gnt, bus.d_gnt}), 32'h0);
        chk("squash mem_en", 32'(bus.mem_en), 32'h0);
        chk("squash mem_we", 32'(bus.mem_we), 32'h0);
        chk("squash mem_addr", 32'(bus.mem_addr), 32'h0);
        chk("squash if_rdata", bus.if_rdata, 32'h0);
        chk("squash d_rdata", bus.d_rdata, 32'h0);
        @(negedge clk);
        drive(1'b0, 14'h0, 1'b0, 4'h0, 14'h0, 32'h0, 32'h5A5A);
        rst = 1'b1;
        @(negedge clk);
        #2;
        chk("post-rst if_rvalid", 32'(bus.if_rvalid), 32'h0);
        chk("post-rst if_rdata", bus.if_rdata, 32'h0);

        // first grant on the first edge after release, IDLE tie goes to data in both policies
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 14'h60, 1'b1, 4'h0, 14'h61, 32'h0, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        #2;
        chk("release d_gnt", 32'(bus.d_gnt), 32'h1);
        chk("release if_gnt", 32'(bus.if_gnt), 32'h0);
        cycle(1'b0, 14'h0, 1'b0, 4'h0, 14'h0, 32'h0, 32'hCAFE);
        chk("release d_rvalid", 32'(bus.d_rvalid), 32'h1);
        chk("release d_rdata", bus.d_rdata, 32'hCAFE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    always @(negedge clk)
        if (bus.if_gnt && bus.d_gnt) begin
            errors++;
            $display("FAIL both granted: if_gnt=1 d_gnt=1 required at most one");
        end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 14, word-address width of the shared memory.
REQ-002 Parameter DATA_W, default 32, data width.
REQ-003 Parameter MAX_BURST, default 4, max consecutive grants to one requester while the other is waiting; legal range 1..15.
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 if_req  input  1  instruction-fetch read request, held until granted.
REQ-007 if_addr  input  ADDR_W  fetch word address.
REQ-008 if_gnt  output  1  fetch request accepted this cycle.
REQ-009 if_rvalid  output  1  fetch read data valid.
REQ-010 if_rdata  output  DATA_W  fetch read data.
REQ-011 d_req  input  1  data-port request, held until granted.
REQ-012 d_we  input  4  byte write enables; 0 = read.
REQ-013 d_addr  input  ADDR_W  data word address.
REQ-014 d_wdata  input  DATA_W  store data.
REQ-015 d_gnt  output  1  data request accepted this cycle.
REQ-016 d_rvalid  output  1  data read data valid (reads only).
REQ-017 d_rdata  output  DATA_W  data read data.
REQ-018 mem_en, mem_we[3:0], mem_addr[ADDR_W-1:0], mem_din[DATA_W-1:0]  outputs  single-port sync memory drive.
REQ-019 mem_dout  input  DATA_W  memory read data, valid one cycle after mem_en.

Function
REQ-020 At most one of if_gnt/d_gnt SHALL be high in any cycle.
REQ-021 Grant SHALL be combinational from req and current state; mem_en = if_gnt | d_gnt; mem_addr/mem_we/mem_din SHALL come from the granted port (mem_we = 0 for fetch).
REQ-022 Read latency SHALL be exactly 1: grant in cycle N -> owner's rvalid high in N+1, rdata = mem_dout.
REQ-023 A write grant SHALL produce no rvalid.
REQ-024 Back-to-back grants (every cycle) SHALL be supported; a registered owner tag routes each return.
REQ-025 FSM states: IDLE (no grant last cycle), OWN_IF, OWN_D; state = port granted last cycle.
REQ-026 Only one requester active: it SHALL be granted immediately, regardless of burst count.
REQ-027 Both requesting, IDLE: winner per REQ-036/037.
REQ-028 Both requesting, OWN_x: x keeps grant while burst counter < MAX_BURST, else the other port SHALL be granted and the counter reloads to 1.
REQ-029 Burst counter SHALL increment on each consecutive grant to the same owner, saturate at MAX_BURST, reset to 1 on owner change, clear in IDLE.
REQ-030 No request -> no grant, mem_en = 0, next state IDLE.
REQ-031 Non-owner rdata SHALL hold its last value; rvalid is a one-cycle pulse.

Reset
REQ-032 While rst low: state IDLE, counter 0, owner tag cleared, all gnt/rvalid/mem_en/mem_we 0, rdata 0.
REQ-033 Reset asserted mid-transaction SHALL squash the pending rvalid; no return after release.
REQ-034 First grant possible in the first rising edge after rst deasserts.

Configuration
REQ-035 Macro MEM_ARB_ROUND_ROBIN_EN selects IDLE tie-break policy.
REQ-036 Defined: on IDLE tie, grant the port not granted most recently (1-bit last-winner register, reset to fetch so data wins first).
REQ-037 Undefined: on IDLE tie, data port SHALL win (fixed priority); REQ-028 burst limit still applies.

Structure
REQ-038 Shared package riscv151_arb_pkg: FSM state enum, owner-tag encoding, MAX_BURST legal bounds.
REQ-039 One sub-module, arb_burst_counter (counter + limit compare); the rest flat.

Verification
REQ-040 Reset then if_req only, if_addr=0x10, mem_dout=0xDEADBEEF -> if_gnt same cycle, if_rvalid next cycle, if_rdata=0xDEADBEEF.
REQ-041 d_req write d_we=4'b1111, d_addr=0x20, d_wdata=0x12345678 -> d_gnt, mem_we=1111, mem_din=0x12345678, no d_rvalid.
REQ-042 Both held high 12 cycles, MAX_BURST=4 -> grant pattern 4 data, 4 fetch, 4 data; never both granted.
REQ-043 IDLE tie with macro on, last winner data -> fetch granted; macro off -> data granted.
REQ-044 rst pulled low the cycle after a fetch read grant -> no if_rvalid, all outputs 0, state IDLE.
REQ-045 Alternating single requests every cycle -> each read returns to the correct port with 1-cycle latency, no cross-routing.
